// File: rtl/edge_timestamper_if.sv
// ---------------------------------------------------------------------------
// edge_timestamper_if
//   Event readout channel of the edge timestamper: show-ahead FIFO head with
//   a valid/ready handshake.
//
//   Parameter
//     TS_W      timestamp / interval width (CNT_W + PT_W of the producer)
//   Signals
//     ev_valid  producer -> consumer : head entry is valid
//     ev_ready  consumer -> producer : consumer accepts the head
//     ev_time   producer -> consumer : head timestamp {coarse, ptime}
//     ev_delta  producer -> consumer : head interval to previous edge
//     ev_level  producer -> consumer : pin level after the edge
//     ev_first  producer -> consumer : first edge since reset / enable rise
//   Modports
//     master    producer side (edge_timestamper)
//     slave     consumer side
// ---------------------------------------------------------------------------
interface edge_timestamper_if #(
   parameter int TS_W = 19
);
   logic            ev_valid;
   logic            ev_ready;
   logic [TS_W-1:0] ev_time;
   logic [TS_W-1:0] ev_delta;
   logic            ev_level;
   logic            ev_first;

   modport master (
      output ev_valid,
      output ev_time,
      output ev_delta,
      output ev_level,
      output ev_first,
      input  ev_ready
   );

   modport slave (
      input  ev_valid,
      input  ev_time,
      input  ev_delta,
      input  ev_level,
      input  ev_first,
      output ev_ready
   );
endinterface

// File: rtl/edge_timestamper.sv
// ---------------------------------------------------------------------------
// edge_timestamper
//   Turns capture-stage edge strobes into absolute timestamps plus the
//   interval since the previous edge, buffers them in a show-ahead FIFO and
//   hands them out over a valid/ready channel. Single clock (clk300).
//
//   Ports
//     clk300      clock, all logic on the rising edge
//     rst_n       synchronous active-low reset
//     enable      1 = coarse counter runs and strobes are accepted
//     str         edge strobe, one cycle per edge
//     ptime       fine phase of the edge, valid with str
//     pin_lvl     pin level after the edge, valid with str
//     ovf_clr     clears ovf and drop_cnt (a same-cycle drop wins)
//     ev          event readout channel (master modport)
//     fifo_count  FIFO occupancy
//     ovf         sticky overflow flag
//     drop_cnt    dropped events, saturating at 255
// ---------------------------------------------------------------------------
module edge_timestamper #(
   parameter int CNT_W      = 16,
   parameter int PT_W       = 3,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                        clk300,
   input  logic                        rst_n,
   input  logic                        enable,
   input  logic                        str,
   input  logic [PT_W-1:0]             ptime,
   input  logic                        pin_lvl,
   input  logic                        ovf_clr,
   edge_timestamper_if.master          ev,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count,
   output logic                        ovf,
   output logic [7:0]                  drop_cnt
);
   localparam int TS_W = CNT_W + PT_W;
   localparam int AW   = $clog2(FIFO_DEPTH);

   localparam logic [CNT_W-1:0] COARSE_ONE = CNT_W'(1);
   localparam logic [AW-1:0]    PTR_ONE    = AW'(1);
   localparam logic [AW:0]      CNT_ONE    = (AW+1)'(1);
   localparam logic [AW:0]      DEPTH_C    = (AW+1)'(FIFO_DEPTH);

   typedef struct packed {
      logic            level;
      logic            first;
      logic [TS_W-1:0] ts;
      logic [TS_W-1:0] delta;
   } entry_t;

   // Saturating 8-bit increment for the drop counter.
   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      sat_inc8 = (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   logic [CNT_W-1:0] coarse_r;

   logic             s1_valid_r;
   logic [TS_W-1:0]  s1_ts_r;
   logic             s1_level_r;
   logic             s1_first_r;

   logic             s2_valid_r;
   entry_t           s2_entry_r;

   logic [TS_W-1:0]  prev_ts_r;
   logic             prev_valid_r;

   entry_t           mem_r [FIFO_DEPTH];
   logic [AW-1:0]    wr_ptr_r;
   logic [AW-1:0]    rd_ptr_r;
   logic [AW:0]      count_r;
   entry_t           head_r;
   logic             head_valid_r;
   logic             ovf_r;
   logic [7:0]       drop_cnt_r;

   logic [TS_W-1:0]  delta_s;
   logic             pop_s;
   logic             full_s;
   logic             push_s;
   logic             drop_s;
   logic [AW-1:0]    rd_nxt_s;
   logic [AW:0]      count_nxt_s;
   entry_t           head_nxt_s;

   // Interval, push/pop/drop decisions and next FIFO head.
   always_comb begin
      delta_s     = s1_first_r ? '0 : (s1_ts_r - prev_ts_r);
      pop_s       = head_valid_r & ev.ev_ready;
      full_s      = (count_r == DEPTH_C);
      push_s      = s2_valid_r & (~full_s | pop_s);
      drop_s      = s2_valid_r & full_s & ~pop_s;
      rd_nxt_s    = pop_s ? (rd_ptr_r + PTR_ONE) : rd_ptr_r;
      count_nxt_s = count_r;
      case ({push_s, pop_s})
         2'b10:   count_nxt_s = count_r + CNT_ONE;
         2'b01:   count_nxt_s = count_r - CNT_ONE;
         default: count_nxt_s = count_r;
      endcase
      // The next head is the entry being written this cycle when the read
      // pointer lands on the write slot (empty FIFO, or last entry popped).
      if (count_nxt_s == '0) begin
         head_nxt_s = '0;
      end else if (push_s && (rd_nxt_s == wr_ptr_r)) begin
         head_nxt_s = s2_entry_r;
      end else begin
         head_nxt_s = mem_r[rd_nxt_s];
      end
   end

   // Coarse counter, capture stage and interval stage.
   always_ff @(posedge clk300) begin
      if (!rst_n) begin
         coarse_r     <= '0;
         s1_valid_r   <= 1'b0;
         s1_ts_r      <= '0;
         s1_level_r   <= 1'b0;
         s1_first_r   <= 1'b0;
         s2_valid_r   <= 1'b0;
         s2_entry_r   <= '0;
         prev_ts_r    <= '0;
         prev_valid_r <= 1'b0;
      end else begin
         if (enable) begin
            coarse_r <= coarse_r + COARSE_ONE;
         end
         s1_valid_r <= str & enable;
         if (str && enable) begin
            s1_ts_r    <= {coarse_r, ptime};
            s1_level_r <= pin_lvl;
            // An edge still in stage 1 counts as a predecessor for
            // back-to-back strobes.
            s1_first_r <= ~(prev_valid_r | s1_valid_r);
         end
         s2_valid_r <= s1_valid_r;
         if (s1_valid_r) begin
            s2_entry_r <= {s1_level_r, s1_first_r, s1_ts_r, delta_s};
            prev_ts_r  <= s1_ts_r;
         end
         // Holding the flag clear while disabled restarts the interval
         // chain at the next enable rise.
         if (!enable) begin
            prev_valid_r <= 1'b0;
         end else if (s1_valid_r) begin
            prev_valid_r <= 1'b1;
         end
      end
   end

   // FIFO pointers, occupancy, registered head and overflow bookkeeping.
   always_ff @(posedge clk300) begin
      if (!rst_n) begin
         wr_ptr_r     <= '0;
         rd_ptr_r     <= '0;
         count_r      <= '0;
         head_r       <= '0;
         head_valid_r <= 1'b0;
         ovf_r        <= 1'b0;
         drop_cnt_r   <= 8'd0;
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end
         rd_ptr_r     <= rd_nxt_s;
         count_r      <= count_nxt_s;
         head_r       <= head_nxt_s;
         head_valid_r <= (count_nxt_s != '0);
         if (drop_s) begin
            ovf_r      <= 1'b1;
            drop_cnt_r <= ovf_clr ? 8'd1 : sat_inc8(drop_cnt_r);
         end else if (ovf_clr) begin
            ovf_r      <= 1'b0;
            drop_cnt_r <= 8'd0;
         end
      end
   end

   // FIFO storage; contents are don't-care until written.
   always_ff @(posedge clk300) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= s2_entry_r;
      end
   end

   assign ev.ev_valid = head_valid_r;
   assign ev.ev_time  = head_r.ts;
   assign ev.ev_delta = head_r.delta;
   assign ev.ev_level = head_r.level;
   assign ev.ev_first = head_r.first;
   assign fifo_count  = count_r;
   assign ovf         = ovf_r;
   assign drop_cnt    = drop_cnt_r;
endmodule

// File: tb/tb_edge_timestamper.sv
// ---------------------------------------------------------------------------
// tb_edge_timestamper
//   Directed bench for edge_timestamper (CNT_W=16, PT_W=3, FIFO_DEPTH=8).
//   Inputs change 1 time unit after the rising edge, outputs are sampled
//   there as well. After do_reset the next rising edge sees coarse = 0, so a
//   strobe driven after j further ticks is stamped with coarse = j.
// ---------------------------------------------------------------------------
module tb_edge_timestamper;
   logic       clk300 = 1'b0;
   logic       rst_n;
   logic       enable;
   logic       str;
   logic [2:0] ptime;
   logic       pin_lvl;
   logic       ovf_clr;
   logic [3:0] fifo_count;
   logic       ovf;
   logic [7:0] drop_cnt;

   int total = 0;
   int bad   = 0;

   edge_timestamper_if #(.TS_W(19)) ev_if ();

   edge_timestamper #(
      .CNT_W(16), .PT_W(3), .FIFO_DEPTH(8)
   ) dut (
      .clk300     (clk300),
      .rst_n      (rst_n),
      .enable     (enable),
      .str        (str),
      .ptime      (ptime),
      .pin_lvl    (pin_lvl),
      .ovf_clr    (ovf_clr),
      .ev         (ev_if),
      .fifo_count (fifo_count),
      .ovf        (ovf),
      .drop_cnt   (drop_cnt)
   );

   always #5 clk300 = ~clk300;

   task automatic tick();
      @(posedge clk300);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; enable = 1'b0; str = 1'b0; ptime = 3'd0; pin_lvl = 1'b0;
      ovf_clr = 1'b0; ev_if.ev_ready = 1'b0;
      tick();
      rst_n = 1'b1; enable = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; enable = 1'b1; str = 1'b1; ptime = 3'd5; pin_lvl = 1'b1;
      ovf_clr = 1'b0; ev_if.ev_ready = 1'b1;
      tick(); tick(); tick();
      total++; if (ev_if.ev_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0d exp=0", ev_if.ev_valid); end
      total++; if (ev_if.ev_time !== 19'd0) begin bad++; $display("FAIL reset_time got=%0d exp=0", ev_if.ev_time); end
      total++; if (ev_if.ev_delta !== 19'd0) begin bad++; $display("FAIL reset_delta got=%0d exp=0", ev_if.ev_delta); end
      total++; if ({ev_if.ev_level, ev_if.ev_first} !== 2'b00) begin bad++; $display("FAIL reset_lvl_first got=%b%b exp=00", ev_if.ev_level, ev_if.ev_first); end
      total++; if (fifo_count !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", fifo_count); end
      total++; if ({ovf, drop_cnt} !== 9'd0) begin bad++; $display("FAIL reset_ovf_drop got=%0d/%0d exp=0/0", ovf, drop_cnt); end
   endtask

   task automatic test_basic();
      do_reset();
      repeat (5) tick();
      str = 1'b1; ptime = 3'd3; pin_lvl = 1'b1;
      tick();                                   // coarse = 5
      str = 1'b0;
      tick();
      total++; if (ev_if.ev_valid !== 1'b0) begin bad++; $display("FAIL basic_latency_early got=%0d exp=0", ev_if.ev_valid); end
      tick();
      total++; if (ev_if.ev_valid !== 1'b1) begin bad++; $display("FAIL basic_latency got=%0d exp=1", ev_if.ev_valid); end
      total++; if (ev_if.ev_time !== 19'd43) begin bad++; $display("FAIL basic_e0_time got=%0d exp=43", ev_if.ev_time); end
      total++; if (ev_if.ev_delta !== 19'd0) begin bad++; $display("FAIL basic_e0_delta got=%0d exp=0", ev_if.ev_delta); end
      total++; if ({ev_if.ev_first, ev_if.ev_level} !== 2'b11) begin bad++; $display("FAIL basic_e0_first_lvl got=%b%b exp=11", ev_if.ev_first, ev_if.ev_level); end
      repeat (4) tick();
      str = 1'b1; ptime = 3'd1; pin_lvl = 1'b0;
      tick();                                   // coarse = 12
      str = 1'b0;
      tick(); tick();
      total++; if (fifo_count !== 4'd2) begin bad++; $display("FAIL basic_count got=%0d exp=2", fifo_count); end
      total++; if (ev_if.ev_time !== 19'd43) begin bad++; $display("FAIL basic_head_hold got=%0d exp=43", ev_if.ev_time); end
      ev_if.ev_ready = 1'b1;
      tick();
      ev_if.ev_ready = 1'b0;
      total++; if (ev_if.ev_time !== 19'd97) begin bad++; $display("FAIL basic_e1_time got=%0d exp=97", ev_if.ev_time); end
      total++; if (ev_if.ev_delta !== 19'd54) begin bad++; $display("FAIL basic_e1_delta got=%0d exp=54", ev_if.ev_delta); end
      total++; if ({ev_if.ev_first, ev_if.ev_level} !== 2'b00) begin bad++; $display("FAIL basic_e1_first_lvl got=%b%b exp=00", ev_if.ev_first, ev_if.ev_level); end
      total++; if (fifo_count !== 4'd1) begin bad++; $display("FAIL basic_count_pop got=%0d exp=1", fifo_count); end
      ev_if.ev_ready = 1'b1;
      tick();
      ev_if.ev_ready = 1'b0;
      total++; if (ev_if.ev_valid !== 1'b0) begin bad++; $display("FAIL basic_empty got=%0d exp=0", ev_if.ev_valid); end
   endtask

   // Strobe i at coarse i with ptime i: retained entry i has ts = 9*i.
   task automatic test_overflow();
      do_reset();
      for (int i = 0; i < 10; i++) begin
         str = 1'b1; ptime = 3'(i); pin_lvl = i[0];
         tick();
      end
      str = 1'b0;
      tick(); tick();
      total++; if (fifo_count !== 4'd8) begin bad++; $display("FAIL ovf_count got=%0d exp=8", fifo_count); end
      total++; if (ovf !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%0d exp=1", ovf); end
      total++; if (drop_cnt !== 8'd2) begin bad++; $display("FAIL ovf_drop_cnt got=%0d exp=2", drop_cnt); end
      ovf_clr = 1'b1;
      tick();
      ovf_clr = 1'b0;
      total++; if ({ovf, drop_cnt} !== 9'd0) begin bad++; $display("FAIL ovf_clr got=%0d/%0d exp=0/0", ovf, drop_cnt); end
      // One more drop with ovf_clr asserted on the push edge: drop wins.
      str = 1'b1;
      tick();
      str = 1'b0;
      tick();
      ovf_clr = 1'b1;
      tick();
      ovf_clr = 1'b0;
      total++; if ({ovf, drop_cnt} !== {1'b1, 8'd1}) begin bad++; $display("FAIL ovf_clr_vs_drop got=%0d/%0d exp=1/1", ovf, drop_cnt); end
      total++; if (fifo_count !== 4'd8) begin bad++; $display("FAIL ovf_count_hold got=%0d exp=8", fifo_count); end
      ovf_clr = 1'b1;
      tick();
      ovf_clr = 1'b0;
      ev_if.ev_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         total++; if (ev_if.ev_valid !== 1'b1 || ev_if.ev_time !== 19'(9 * i)) begin bad++; $display("FAIL ovf_read_time[%0d] got=%0d/%0d exp=1/%0d", i, ev_if.ev_valid, ev_if.ev_time, 9 * i); end
         total++; if (ev_if.ev_delta !== ((i == 0) ? 19'd0 : 19'd9)) begin bad++; $display("FAIL ovf_read_delta[%0d] got=%0d exp=%0d", i, ev_if.ev_delta, (i == 0) ? 0 : 9); end
         total++; if ({ev_if.ev_first, ev_if.ev_level} !== {(i == 0), i[0]}) begin bad++; $display("FAIL ovf_read_flags[%0d] got=%b%b exp=%b%b", i, ev_if.ev_first, ev_if.ev_level, (i == 0), i[0]); end
         tick();
      end
      ev_if.ev_ready = 1'b0;
      total++; if (ev_if.ev_valid !== 1'b0 || fifo_count !== 4'd0) begin bad++; $display("FAIL ovf_drained got=%0d/%0d exp=0/0", ev_if.ev_valid, fifo_count); end
   endtask

   // Strobe at edge R+c (c=1..13) has coarse c-1, ptime 3: ts = 8*(c-1)+3.
   // The FIFO fills after edge R+10; ready from edge R+11 pops while
   // strobes 8..12 are pushed on edges R+11..R+15.
   task automatic test_full_push_pop();
      do_reset();
      for (int c = 1; c <= 23; c++) begin
         str = (c <= 13); ptime = 3'd3; pin_lvl = 1'b1;
         ev_if.ev_ready = (c >= 11);
         tick();
         if (c == 10) begin
            total++; if (fifo_count !== 4'd8) begin bad++; $display("FAIL full_count_filled got=%0d exp=8", fifo_count); end
            total++; if (ev_if.ev_time !== 19'd3 || ev_if.ev_first !== 1'b1 || ev_if.ev_delta !== 19'd0) begin bad++; $display("FAIL full_head0 got=%0d/%0d/%0d exp=3/1/0", ev_if.ev_time, ev_if.ev_first, ev_if.ev_delta); end
         end
         if (c >= 11 && c <= 15) begin
            total++; if (fifo_count !== 4'd8 || ovf !== 1'b0) begin bad++; $display("FAIL full_pushpop[%0d] count/ovf got=%0d/%0d exp=8/0", c, fifo_count, ovf); end
         end
         if (c >= 11 && c <= 22) begin
            total++; if (ev_if.ev_valid !== 1'b1 || ev_if.ev_time !== 19'(8 * (c - 10) + 3) || ev_if.ev_delta !== 19'd8) begin bad++; $display("FAIL full_order[%0d] got=%0d/%0d/%0d exp=1/%0d/8", c, ev_if.ev_valid, ev_if.ev_time, ev_if.ev_delta, 8 * (c - 10) + 3); end
         end
         if (c == 23) begin
            total++; if (ev_if.ev_valid !== 1'b0 || fifo_count !== 4'd0) begin bad++; $display("FAIL full_drained got=%0d/%0d exp=0/0", ev_if.ev_valid, fifo_count); end
         end
      end
      str = 1'b0; ev_if.ev_ready = 1'b0;
      total++; if (drop_cnt !== 8'd0) begin bad++; $display("FAIL full_no_drop got=%0d exp=0", drop_cnt); end
   endtask

   task automatic test_mid_reset();
      do_reset();
      for (int i = 0; i < 3; i++) begin
         str = 1'b1; ptime = 3'd1; pin_lvl = 1'b1;
         tick();
      end
      str = 1'b0;
      tick(); tick();
      total++; if (fifo_count !== 4'd3) begin bad++; $display("FAIL midrst_buffered got=%0d exp=3", fifo_count); end
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      total++; if (ev_if.ev_valid !== 1'b0 || fifo_count !== 4'd0) begin bad++; $display("FAIL midrst_flush got=%0d/%0d exp=0/0", ev_if.ev_valid, fifo_count); end
      total++; if ({ovf, drop_cnt} !== 9'd0 || ev_if.ev_time !== 19'd0) begin bad++; $display("FAIL midrst_clear got=%0d/%0d/%0d exp=0/0/0", ovf, drop_cnt, ev_if.ev_time); end
      repeat (3) tick();
      str = 1'b1; ptime = 3'd5; pin_lvl = 1'b0;
      tick();                                   // coarse = 3
      str = 1'b0;
      tick(); tick();
      total++; if (ev_if.ev_valid !== 1'b1 || ev_if.ev_time !== 19'd29) begin bad++; $display("FAIL midrst_time got=%0d/%0d exp=1/29", ev_if.ev_valid, ev_if.ev_time); end
      total++; if (ev_if.ev_first !== 1'b1 || ev_if.ev_delta !== 19'd0) begin bad++; $display("FAIL midrst_first got=%0d/%0d exp=1/0", ev_if.ev_first, ev_if.ev_delta); end
   endtask

   task automatic test_enable_toggle();
      do_reset();
      tick(); tick();
      str = 1'b1; ptime = 3'd2; pin_lvl = 1'b1;
      tick();                                   // coarse = 2
      str = 1'b0;
      tick(); tick();                           // edge R+5, coarse now 5
      total++; if (ev_if.ev_valid !== 1'b1 || ev_if.ev_time !== 19'd18) begin bad++; $display("FAIL en_a_time got=%0d/%0d exp=1/18", ev_if.ev_valid, ev_if.ev_time); end
      enable = 1'b0;
      for (int c = 6; c <= 25; c++) begin
         str = (c % 3 == 0); ptime = 3'(c); pin_lvl = c[0];
         ev_if.ev_ready = (c == 6);
         tick();
         if (c == 6) begin
            total++; if (ev_if.ev_valid !== 1'b0) begin bad++; $display("FAIL en_pop_disabled got=%0d exp=0", ev_if.ev_valid); end
         end
      end
      str = 1'b0; ev_if.ev_ready = 1'b0;
      total++; if (fifo_count !== 4'd0 || ev_if.ev_valid !== 1'b0) begin bad++; $display("FAIL en_ignored got=%0d/%0d exp=0/0", fifo_count, ev_if.ev_valid); end
      enable = 1'b1;
      str = 1'b1; ptime = 3'd7; pin_lvl = 1'b0;
      tick();                                   // coarse still 5
      str = 1'b0;
      tick(); tick();
      total++; if (ev_if.ev_valid !== 1'b1 || ev_if.ev_time !== 19'd47) begin bad++; $display("FAIL en_b_time got=%0d/%0d exp=1/47", ev_if.ev_valid, ev_if.ev_time); end
      total++; if (ev_if.ev_first !== 1'b1 || ev_if.ev_delta !== 19'd0 || fifo_count !== 4'd1) begin bad++; $display("FAIL en_b_first got=%0d/%0d/%0d exp=1/0/1", ev_if.ev_first, ev_if.ev_delta, fifo_count); end
   endtask

   task automatic test_wrap();
      do_reset();
      repeat (65535) tick();
      str = 1'b1; ptime = 3'd6; pin_lvl = 1'b1;
      tick();                                   // coarse = 0xFFFF
      str = 1'b0;
      tick();                                   // coarse = 0x0000
      str = 1'b1; ptime = 3'd2; pin_lvl = 1'b0;
      tick();                                   // coarse = 0x0001
      str = 1'b0;
      tick(); tick();
      total++; if (ev_if.ev_time !== 19'd524286 || fifo_count !== 4'd2) begin bad++; $display("FAIL wrap_prev got=%0d/%0d exp=524286/2", ev_if.ev_time, fifo_count); end
      ev_if.ev_ready = 1'b1;
      tick();
      ev_if.ev_ready = 1'b0;
      total++; if (ev_if.ev_time !== 19'd10) begin bad++; $display("FAIL wrap_time got=%0d exp=10", ev_if.ev_time); end
      total++; if (ev_if.ev_delta !== 19'd12 || ev_if.ev_first !== 1'b0) begin bad++; $display("FAIL wrap_delta got=%0d/%0d exp=12/0", ev_if.ev_delta, ev_if.ev_first); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_overflow();
      test_full_push_pop();
      test_mid_reset();
      test_enable_toggle();
      test_wrap();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
